power_rail_monitor: RTL and testbench
=====================================

Name: power_rail_monitor

Overview:
- Upstream supervisor for the board power-management path.
- Steps the 3-bit external voltage mux across up to 8 rail dividers and integrates the digital comparator line for each rail, where 1 means the rail is above threshold.
- Debounces faults across scans and drives kill_sw, which feeds the global shutdown/disable logic.
- kill_sw=1 means power enabled; kill_sw=0 means killed.

Parameters:
- SETTLE_CYCLES, 500: clk cycles to wait after a mux change before sampling.
- WINDOW_CYCLES, 1024: clk cycles in which data_in is integrated per channel.
- FAULT_SCANS, 3: consecutive bad scans of one channel needed to trip the kill.
- RECOVER_SCANS, 8: consecutive all-good scans needed for auto-recover (optional feature only).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scanning enabled.
- ch_mask  input  8  bit i=1 means channel i is monitored.
- data_in  input  1  asynchronous comparator result from the mux.
- clear_kill  input  1  one-cycle pulse that re-arms after a trip.
- mux  output  3  current rail select.
- kill_sw  output  1  1 = power enabled, 0 = killed.
- rail_good  output  8  per-channel result of the last judgement.
- fault_ch  output  3  channel that caused the most recent trip.
- tripped  output  1  latched trip flag.
- scan_done  output  1  one-cycle pulse at the end of each full pass.

Behaviour:
- Reset values:
  - mux=0, kill_sw=0, rail_good=8'hFF, fault_ch=0, tripped=0, scan_done=0.
  - All counters cleared; FSM in IDLE.
- Input synchronisation:
  - data_in passes through a 2-flop synchronizer; only the synchronized value is counted.
  - Sync latency is 2 cycles and is absorbed by SETTLE.
- FSM states: IDLE, SELECT, SETTLE, SAMPLE, JUDGE.
- IDLE:
  - If enable=1 and ch_mask!=0, go to SELECT with the lowest set channel.
  - Otherwise stay in IDLE; mux and kill_sw hold their values.
- SELECT (1 cycle): drive mux=ch, clear the settle counter and the high counter.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Lasts WINDOW_CYCLES cycles; hi_cnt increments on each cycle where the synchronized data is 1.
  - hi_cnt width is clog2(WINDOW_CYCLES+1) and never overflows.
- JUDGE (1 cycle):
  - Good when hi_cnt >= WINDOW_CYCLES/2 (integer division); set rail_good[ch] to the result.
  - Good: fault_cnt[ch] is cleared.
  - Bad: fault_cnt[ch] increments, saturating at FAULT_SCANS.
  - When fault_cnt[ch] reaches FAULT_SCANS: tripped=1, kill_sw=0, fault_ch=ch. This takes effect on the next clock edge.
  - Next channel: the next set bit of ch_mask above ch, sampled in JUDGE; go to SELECT with it.
  - If no higher set bit exists, the scan ends: scan_done=1 for exactly the cycle after JUDGE, then the FSM goes to SELECT at the lowest set channel (or to IDLE if ch_mask is now 0).
- Masked channels:
  - Skipped entirely, costing zero cycles.
  - rail_good bit forced to 1 and fault_cnt cleared.
- Per-channel pass time: 1 + SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles.
- Arming:
  - At the end of a scan, if tripped=0 and every monitored channel judged good in that scan, kill_sw goes to 1.
  - A scan where a channel is bad but not yet tripped leaves kill_sw unchanged.
  - So after reset, power is enabled only after the first fully good scan.
- clear_kill:
  - Clears tripped and all fault_cnt; kill_sw stays 0 until the next fully good scan completes.
  - If clear_kill coincides with a trip in JUDGE, the trip wins.
  - Ignored when tripped=0.
- enable falls mid-operation:
  - Abort to IDLE on the next edge; the partial channel is discarded.
  - rail_good, fault_cnt, kill_sw and tripped hold.
  - Scanning restarts from the lowest set channel when enable returns.
- ch_mask changes mid-scan: the current channel completes; the new mask applies from the next channel selection.
- Reset mid-operation returns everything to the reset values above, so kill_sw=0.

Optional Feature:
- Macro: PWR_MON_AUTO_RECOVER_EN.
- Defined:
  - While tripped=1, count consecutive scans in which all monitored channels are good.
  - After RECOVER_SCANS such scans: clear tripped and fault_cnt, and set kill_sw=1 in the same cycle as scan_done.
  - Any bad judgement resets this recovery count.
  - clear_kill still works as above.
- Undefined: a trip is latched until clear_kill; no recover counter is built.

Test Plan (SETTLE_CYCLES=4, WINDOW_CYCLES=16, FAULT_SCANS=3, RECOVER_SCANS=2):
- Reset, enable=1, ch_mask=8'h05, data_in=1 -> mux sequence 0,2,0,…; each channel lasts 22 cycles; first scan_done 44 cycles after SELECT of ch0; kill_sw=1 on that scan_done; rail_good=8'hFF.
- Duty threshold, mask 8'h01 -> 8/16 highs judged good and 7/16 judged bad.
- Ch2 low for 3 scans, mask 8'h05, data_in=1 on ch0 -> rail_good[2]=0 after scan 1; kill_sw=0, tripped=1, fault_ch=2 after the 3rd JUDGE of ch2.
- Ch2 low for 2 scans then good -> fault_cnt clears, kill_sw stays 1.
- Recovery, without the macro:
  - After a trip with all rails good: kill_sw stays 0.
  - Pulse clear_kill: kill_sw=1 at the next scan_done.
  - clear_kill in the same cycle as a trip: tripped stays 1.
- enable falls during SAMPLE -> IDLE next cycle; outputs hold; restart begins at the lowest channel.
- With PWR_MON_AUTO_RECOVER_EN: trip, then 2 all-good scans -> kill_sw=1 at the 2nd scan_done without clear_kill.

Source files
------------

// File: rtl/power_rail_monitor.sv
// Rail supervisor: scans up to 8 muxed rails, integrates the comparator per rail, debounces faults into kill_sw.
// Optional PWR_MON_AUTO_RECOVER_EN: auto re-arm after RECOVER_SCANS consecutive all-good scans while tripped.
module power_rail_monitor #(
  parameter int SETTLE_CYCLES = 500,
  parameter int WINDOW_CYCLES = 1024,
  parameter int FAULT_SCANS   = 3,
  parameter int RECOVER_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  input  logic       data_in,
  input  logic       clear_kill,
  output logic [2:0] mux,
  output logic       kill_sw,
  output logic [7:0] rail_good,
  output logic [2:0] fault_ch,
  output logic       tripped,
  output logic       scan_done
);

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HI_W    = $clog2(WINDOW_CYCLES + 1);
  localparam int FC_W    = $clog2(FAULT_SCANS + 1);

  generate
    if (SETTLE_CYCLES < 1 || WINDOW_CYCLES < 2 || FAULT_SCANS < 1 || RECOVER_SCANS < 1) begin : g_bad_param
      $error("power_rail_monitor: invalid parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_SAMPLE, S_JUDGE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [HI_W-1:0]   hi_cnt;
  logic [FC_W-1:0]   fault_cnt [8];
  logic              d_meta, d_sync;
  logic              scan_bad;

  logic [3:0]        first_sel, next_sel;
  logic              settle_last, sample_last;
  logic              judge_good, trip_now, scan_end, all_good;
  logic [FC_W-1:0]   fc_cur, fc_inc;

  logic              ld_ch, cnt_clr, cnt_inc, hi_clr, hi_inc, judge_en;
  logic [2:0]        sel_ch;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign first_sel   = find_ch(ch_mask, 4'd0);
  assign next_sel    = find_ch(ch_mask, {1'b0, mux} + 4'd1);
  assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign sample_last = (cnt == CNT_W'(WINDOW_CYCLES - 1));
  assign judge_good  = (hi_cnt >= HI_W'(WINDOW_CYCLES / 2));
  assign fc_cur      = fault_cnt[mux];
  assign fc_inc      = (fc_cur == FC_W'(FAULT_SCANS)) ? fc_cur : fc_cur + 1'b1;
  assign trip_now    = judge_en && !judge_good && (fc_inc == FC_W'(FAULT_SCANS));
  assign scan_end    = judge_en && !next_sel[3];
  assign all_good    = !scan_bad && judge_good;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_meta <= 1'b0;
      d_sync <= 1'b0;
    end else begin
      d_meta <= data_in;
      d_sync <= d_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable && first_sel[3]) state_nxt = S_SELECT;
      S_SELECT: state_nxt = S_SETTLE;
      S_SETTLE: if (settle_last) state_nxt = S_SAMPLE;
      S_SAMPLE: if (sample_last) state_nxt = S_JUDGE;
      S_JUDGE:  state_nxt = (next_sel[3] || first_sel[3]) ? S_SELECT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && !enable) state_nxt = S_IDLE;
  end

  always_comb begin
    ld_ch    = 1'b0;
    sel_ch   = first_sel[2:0];
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    hi_clr   = 1'b0;
    hi_inc   = 1'b0;
    judge_en = 1'b0;
    case (state)
      S_IDLE:   ld_ch = enable && first_sel[3];
      S_SELECT: begin
        cnt_clr = 1'b1;
        hi_clr  = 1'b1;
      end
      S_SETTLE: begin
        cnt_clr = settle_last;
        cnt_inc = !settle_last;
      end
      S_SAMPLE: begin
        cnt_inc = 1'b1;
        hi_inc  = d_sync;
      end
      S_JUDGE: begin
        judge_en = enable;
        ld_ch    = enable && (next_sel[3] || first_sel[3]);
        if (next_sel[3]) sel_ch = next_sel[2:0];
      end
      default: ;
    endcase
  end

`ifdef PWR_MON_AUTO_RECOVER_EN
  localparam int RC_W = $clog2(RECOVER_SCANS + 1);
  logic [RC_W-1:0] rec_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mux       <= 3'd0;
      cnt       <= '0;
      hi_cnt    <= '0;
      kill_sw   <= 1'b0;
      rail_good <= 8'hFF;
      fault_ch  <= 3'd0;
      tripped   <= 1'b0;
      scan_done <= 1'b0;
      scan_bad  <= 1'b0;
      for (int i = 0; i < 8; i++) fault_cnt[i] <= '0;
`ifdef PWR_MON_AUTO_RECOVER_EN
      rec_cnt   <= '0;
`endif
    end else begin
      scan_done <= scan_end;
      if (ld_ch) mux <= sel_ch;
      if (ld_ch && state == S_IDLE) scan_bad <= 1'b0;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (hi_clr)                                         hi_cnt <= '0;
      else if (hi_inc && hi_cnt != HI_W'(WINDOW_CYCLES)) hi_cnt <= hi_cnt + 1'b1;

      if (clear_kill && tripped) begin
        tripped <= 1'b0;
        for (int i = 0; i < 8; i++) fault_cnt[i] <= '0;
`ifdef PWR_MON_AUTO_RECOVER_EN
        rec_cnt <= '0;
`endif
      end

      // Judgement is written after the clear so a coincident trip wins.
      if (judge_en) begin
        rail_good[mux] <= judge_good;
        fault_cnt[mux] <= judge_good ? '0 : fc_inc;
        if (trip_now) begin
          tripped  <= 1'b1;
          kill_sw  <= 1'b0;
          fault_ch <= mux;
        end
        if (scan_end) begin
          scan_bad <= 1'b0;
          if (!tripped && !trip_now && all_good) kill_sw <= 1'b1;
        end else begin
          scan_bad <= scan_bad | !judge_good;
        end
`ifdef PWR_MON_AUTO_RECOVER_EN
        if (!judge_good) begin
          rec_cnt <= '0;
        end else if (scan_end && tripped && all_good) begin
          if (rec_cnt == RC_W'(RECOVER_SCANS - 1)) begin
            rec_cnt <= '0;
            tripped <= 1'b0;
            kill_sw <= 1'b1;
            for (int i = 0; i < 8; i++) fault_cnt[i] <= '0;
          end else begin
            rec_cnt <= rec_cnt + 1'b1;
          end
        end
`endif
      end

      for (int i = 0; i < 8; i++) begin
        if (!ch_mask[i]) begin
          rail_good[i] <= 1'b1;
          fault_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_power_rail_monitor.sv
// Directed bench for power_rail_monitor with SETTLE=4, WINDOW=16, FAULT=3, RECOVER=2 (22-cycle channel pass).
module tb_power_rail_monitor;

  logic       clk = 1'b0;
  logic       reset, enable, data_in, clear_kill;
  logic [7:0] ch_mask;
  logic [2:0] mux;
  logic       kill_sw;
  logic [7:0] rail_good;
  logic [2:0] fault_ch;
  logic       tripped;
  logic       scan_done;

  int errors = 0;
  int checks = 0;
  bit ch2_low = 1'b0;

  always #5 clk = ~clk;

  power_rail_monitor #(
    .SETTLE_CYCLES(4), .WINDOW_CYCLES(16), .FAULT_SCANS(3), .RECOVER_SCANS(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .data_in(data_in),
    .clear_kill(clear_kill), .mux(mux), .kill_sw(kill_sw), .rail_good(rail_good),
    .fault_ch(fault_ch), .tripped(tripped), .scan_done(scan_done)
  );

  // One clock; outputs are then stable and the comparator follows the selected rail.
  task automatic step();
    @(posedge clk);
    #1;
    data_in = (ch2_low && mux == 3'd2) ? 1'b0 : 1'b1;
  endtask

  task automatic wait_scan();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (scan_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_scan: scan_done not seen in 200 cycles, required a pulse");
    end
  endtask

  task automatic start(input logic [7:0] m);
    reset = 1'b1; enable = 1'b0; clear_kill = 1'b0; data_in = 1'b1; ch2_low = 1'b0; ch_mask = m;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b1;
    wait_scan();
  endtask

  // One pulse-shaped pass for mask 8'h01, starting at a scan_done cycle: n highs inside the window.
  task automatic run_pass(input int n);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
      data_in = (k >= 8 && k < 8 + n) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ch_mask = 8'h05; data_in = 1'b1; clear_kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mux, kill_sw, rail_good, fault_ch, tripped, scan_done} !== {3'd0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: got mux=%0d kill=%b good=%h fch=%0d trip=%b done=%b, required 0 0 ff 0 0 0",
               mux, kill_sw, rail_good, fault_ch, tripped, scan_done);
    end
    enable = 1'b0;
    reset = 1'b0;
    repeat (5) step();
    checks++;
    if ({mux, kill_sw, scan_done} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: got mux=%0d kill=%b done=%b, required 0 0 0", mux, kill_sw, scan_done);
    end
  endtask

  task automatic test_scan_timing();
    int  first_m2 = 0, second_m2 = 0, first_sd = 0, c = 0;
    logic prev_kill = 1'b0, kill_before = 1'bx, kill_at = 1'bx, sd_after = 1'bx;
    logic [2:0] prev_mux = 3'd0, mux_at = 3'bx;
    logic [7:0] good_at = 8'hxx;
    enable = 1'b1;
    for (c = 1; c <= 70; c++) begin
      step();
      if (mux == 3'd2 && prev_mux != 3'd2) begin
        if (first_m2 == 0) first_m2 = c;
        else if (second_m2 == 0) second_m2 = c;
      end
      if (first_sd != 0 && c == first_sd + 1) sd_after = scan_done;
      if (scan_done === 1'b1 && first_sd == 0) begin
        first_sd = c; kill_before = prev_kill; kill_at = kill_sw; mux_at = mux; good_at = rail_good;
      end
      prev_mux = mux;
      prev_kill = kill_sw;
    end
    checks++;
    if (first_m2 != 23) begin
      errors++; $display("FAIL mux_to_ch2: got cycle %0d, required 23", first_m2);
    end
    checks++;
    if (first_sd != 45) begin
      errors++; $display("FAIL first_scan_done: got cycle %0d, required 45", first_sd);
    end
    checks++;
    if ({kill_before, kill_at, sd_after} !== 3'b010) begin
      errors++; $display("FAIL arm_on_scan: got kill_before=%b kill_at=%b done_after=%b, required 0 1 0",
                         kill_before, kill_at, sd_after);
    end
    checks++;
    if ({mux_at, good_at} !== {3'd0, 8'hFF}) begin
      errors++; $display("FAIL wrap_state: got mux=%0d good=%h, required 0 ff", mux_at, good_at);
    end
    checks++;
    if (second_m2 != 67) begin
      errors++; $display("FAIL second_ch2: got cycle %0d, required 67", second_m2);
    end
  endtask

  task automatic test_duty_threshold();
    start(8'h01);
    run_pass(8);
    checks++;
    if ({scan_done, rail_good[0]} !== 2'b11) begin
      errors++; $display("FAIL duty_8of16: got done=%b good0=%b, required 1 1", scan_done, rail_good[0]);
    end
    run_pass(7);
    checks++;
    if ({scan_done, rail_good[0], kill_sw, tripped} !== 4'b1010) begin
      errors++; $display("FAIL duty_7of16: got done=%b good0=%b kill=%b trip=%b, required 1 0 1 0",
                         scan_done, rail_good[0], kill_sw, tripped);
    end
  endtask

  task automatic test_trip();
    start(8'h05);
    ch2_low = 1'b1;
    wait_scan();
    checks++;
    if ({rail_good, kill_sw, tripped} !== {8'hFB, 1'b1, 1'b0}) begin
      errors++; $display("FAIL trip_scan1: got good=%h kill=%b trip=%b, required fb 1 0", rail_good, kill_sw, tripped);
    end
    wait_scan();
    checks++;
    if ({kill_sw, tripped} !== 2'b10) begin
      errors++; $display("FAIL trip_scan2: got kill=%b trip=%b, required 1 0", kill_sw, tripped);
    end
    wait_scan();
    checks++;
    if ({kill_sw, tripped, fault_ch, rail_good} !== {1'b0, 1'b1, 3'd2, 8'hFB}) begin
      errors++; $display("FAIL trip_scan3: got kill=%b trip=%b fch=%0d good=%h, required 0 1 2 fb",
                         kill_sw, tripped, fault_ch, rail_good);
    end
  endtask

  // Continues from a tripped state with ch2 still low: clear_kill lands in ch2's JUDGE.
  task automatic test_clear_coincide();
    repeat (43) step();
    clear_kill = 1'b1;
    step();
    clear_kill = 1'b0;
    checks++;
    if ({scan_done, tripped, kill_sw} !== 3'b110) begin
      errors++; $display("FAIL clear_vs_trip: got done=%b trip=%b kill=%b, required 1 1 0",
                         scan_done, tripped, kill_sw);
    end
  endtask

  task automatic test_no_auto_recover();
    ch2_low = 1'b0;
    wait_scan();
    checks++;
    if ({kill_sw, tripped} !== 2'b01) begin
      errors++; $display("FAIL good_scan1_tripped: got kill=%b trip=%b, required 0 1", kill_sw, tripped);
    end
    wait_scan();
    checks++;
`ifdef PWR_MON_AUTO_RECOVER_EN
    if ({kill_sw, tripped} !== 2'b10) begin
      errors++; $display("FAIL auto_recover: got kill=%b trip=%b, required 1 0", kill_sw, tripped);
    end
`else
    if ({kill_sw, tripped} !== 2'b01) begin
      errors++; $display("FAIL latched_trip: got kill=%b trip=%b, required 0 1", kill_sw, tripped);
    end
`endif
  endtask

  task automatic test_clear_kill();
    start(8'h05);
    ch2_low = 1'b1;
    repeat (3) wait_scan();
    ch2_low = 1'b0;
    repeat (5) step();
    clear_kill = 1'b1;
    step();
    clear_kill = 1'b0;
    checks++;
    if ({tripped, kill_sw} !== 2'b00) begin
      errors++; $display("FAIL clear_kill_now: got trip=%b kill=%b, required 0 0", tripped, kill_sw);
    end
    wait_scan();
    checks++;
    if ({kill_sw, tripped} !== 2'b10) begin
      errors++; $display("FAIL clear_kill_rearm: got kill=%b trip=%b, required 1 0", kill_sw, tripped);
    end
    ch2_low = 1'b1;
    repeat (2) wait_scan();
    checks++;
    if ({kill_sw, tripped} !== 2'b10) begin
      errors++; $display("FAIL clear_fault_cnt: got kill=%b trip=%b, required 1 0", kill_sw, tripped);
    end
  endtask

  task automatic test_fault_reset_by_good();
    start(8'h05);
    ch2_low = 1'b1;
    repeat (2) wait_scan();
    ch2_low = 1'b0;
    wait_scan();
    checks++;
    if ({kill_sw, tripped, rail_good} !== {1'b1, 1'b0, 8'hFF}) begin
      errors++; $display("FAIL good_after_2bad: got kill=%b trip=%b good=%h, required 1 0 ff",
                         kill_sw, tripped, rail_good);
    end
    ch2_low = 1'b1;
    repeat (2) wait_scan();
    checks++;
    if ({kill_sw, tripped} !== 2'b10) begin
      errors++; $display("FAIL cnt_restart: got kill=%b trip=%b, required 1 0", kill_sw, tripped);
    end
    wait_scan();
    checks++;
    if ({kill_sw, tripped, fault_ch} !== {1'b0, 1'b1, 3'd2}) begin
      errors++; $display("FAIL third_bad_trips: got kill=%b trip=%b fch=%0d, required 0 1 2",
                         kill_sw, tripped, fault_ch);
    end
  endtask

  task automatic test_enable_drop();
    bit sd_seen = 1'b0;
    int c = 0;
    logic [2:0] mux_first = 3'bx;
    start(8'h05);
    repeat (32) step();
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (scan_done === 1'b1) sd_seen = 1'b1;
    end
    checks++;
    if ({sd_seen, mux, kill_sw, rail_good, tripped} !== {1'b0, 3'd2, 1'b1, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL abort_hold: got done_seen=%b mux=%0d kill=%b good=%h trip=%b, required 0 2 1 ff 0",
                         sd_seen, mux, kill_sw, rail_good, tripped);
    end
    enable = 1'b1;
    for (c = 1; c <= 80; c++) begin
      step();
      if (c == 1) mux_first = mux;
      if (scan_done === 1'b1) break;
    end
    checks++;
    if (mux_first !== 3'd0) begin
      errors++; $display("FAIL restart_lowest: got mux=%0d, required 0", mux_first);
    end
    checks++;
    if (c != 45) begin
      errors++; $display("FAIL restart_scan_len: got cycle %0d, required 45", c);
    end
  endtask

  task automatic test_mask_change();
    start(8'h05);
    ch2_low = 1'b1;
    wait_scan();
    checks++;
    if (rail_good !== 8'hFB) begin
      errors++; $display("FAIL mask_pre: got good=%h, required fb", rail_good);
    end
    ch_mask = 8'h01;
    repeat (2) step();
    checks++;
    if (rail_good !== 8'hFF) begin
      errors++; $display("FAIL mask_force_good: got good=%h, required ff", rail_good);
    end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_duty_threshold();
    test_trip();
    test_clear_coincide();
    test_no_auto_recover();
    test_clear_kill();
    test_fault_reset_by_good();
    test_enable_drop();
    test_mask_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
